// File: rtl/sine_quarter_lut_pkg.sv
// Shared types and elaboration-time helpers for the sine waveform stages.
// The quarter-wave table is computed here so the ROM needs no external init file.
package sigwave_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    localparam real PI = 3.14159265358979323846;

    function automatic int mid_code(input int d);
        return 1 << (d - 1);
    endfunction

    function automatic int QROM_DEPTH_F(input int a);
        return 1 << (a - 2);
    endfunction

    // Odd Taylor series; the argument never exceeds pi/2, so 13 terms are far below one LSB.
    function automatic real sin_series(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Entry k samples the middle of its phase step, which makes the quadrant mirror exact.
    function automatic int qrom_entry(input int k, input int a, input int d);
        real theta;
        real val;
        theta = 2.0 * PI * (real'(k) + 0.5) / real'(1 << a);
        val   = real'((1 << (d - 1)) - 1) * sin_series(theta);
        return $rtoi(val + 0.5);
    endfunction

endpackage

// File: rtl/sine_quarter_lut_if.sv
// Sample-stream bundle between the phase source and the sine converter.
// SINE_AMP_SHIFT_EN adds the amp_shift attenuation control.
interface sine_quarter_lut_if #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
);
    logic               en;
    logic [A_WIDTH-1:0] phase;
    logic [D_WIDTH-1:0] dout;
    logic               dout_valid;
`ifdef SINE_AMP_SHIFT_EN
    logic [1:0]         amp_shift;

    modport master (
        output en,
        output phase,
        output amp_shift,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  en,
        input  phase,
        input  amp_shift,
        output dout,
        output dout_valid
    );
`else
    modport master (
        output en,
        output phase,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  en,
        input  phase,
        output dout,
        output dout_valid
    );
`endif
endinterface

// File: rtl/sine_quarter_lut_qrom.sv
// Quarter-wave sine magnitude ROM with a registered read port and no reset.
// Contents come from sigwave_pkg::qrom_entry at elaboration.
module sine_qrom
    import sigwave_pkg::*;
#(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
) (
    input  logic                 clk,
    input  logic [A_WIDTH-3:0]   addr_i,
    output logic [D_WIDTH-2:0]   data_o
);

    localparam int DEPTH = QROM_DEPTH_F(A_WIDTH);
    localparam int MW    = D_WIDTH - 1;

    logic [MW-1:0] rom [DEPTH];
    logic [MW-1:0] rd_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            localparam logic [MW-1:0] ENTRY = MW'(qrom_entry(gi, A_WIDTH, D_WIDTH));
            assign rom[gi] = ENTRY;
        end
    endgenerate

    always_ff @(posedge clk) begin
        rd_q <= rom[addr_i];
    end

    assign data_o = rd_q;

endmodule

// File: rtl/sine_quarter_lut.sv
// Phase word to unsigned midscale-offset sine sample: decode, quarter ROM read, sign/offset.
// Optional SINE_AMP_SHIFT_EN adds a 0..3 bit magnitude right-shift in the last stage.
module sine_quarter_lut
    import sigwave_pkg::*;
#(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    sine_quarter_lut_if.slave bus
);

    localparam int RAW = A_WIDTH - 2;
    localparam int MW  = D_WIDTH - 1;
    localparam logic [D_WIDTH-1:0] MID = D_WIDTH'(mid_code(D_WIDTH));

    quadrant_t          quad;
    logic [RAW-1:0]     idx;
    logic [RAW-1:0]     addr_d;
    logic               neg_d;

    logic [RAW-1:0]     addr_q;
    logic               neg1_q;
    logic               v1_q;
    logic               neg2_q;
    logic               v2_q;
    logic [MW-1:0]      mag;
    logic [D_WIDTH-1:0] mag_ext;
    logic [D_WIDTH-1:0] dout_d;
    logic [D_WIDTH-1:0] dout_q;
    logic               dout_valid_q;

    // Quadrants 1 and 3 walk the table backwards; quadrants 2 and 3 are below midscale.
    always_comb begin
        quad   = quadrant_t'(bus.phase[A_WIDTH-1 -: 2]);
        idx    = bus.phase[RAW-1:0];
        addr_d = idx;
        neg_d  = 1'b0;
        if (quad == Q1 || quad == Q3) begin
            addr_d = ~idx;
        end
        if (quad == Q2 || quad == Q3) begin
            neg_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            neg1_q <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            neg1_q <= neg_d;
            v1_q   <= bus.en;
        end
    end

    sine_qrom #(
        .A_WIDTH (A_WIDTH),
        .D_WIDTH (D_WIDTH)
    ) u_qrom (
        .clk    (clk),
        .addr_i (addr_q),
        .data_o (mag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            neg2_q <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            neg2_q <= neg1_q;
            v2_q   <= v1_q;
        end
    end

    // Magnitude never exceeds MID-1, so neither branch can wrap.
    always_comb begin
`ifdef SINE_AMP_SHIFT_EN
        mag_ext = {1'b0, mag} >> bus.amp_shift;
`else
        mag_ext = {1'b0, mag};
`endif
        dout_d = neg2_q ? (MID - mag_ext) : (MID + mag_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= MID;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= v2_q;
            if (v2_q) begin
                dout_q <= dout_d;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_sine_quarter_lut.sv
// Randomised and directed stimulus against a real-arithmetic sine model; one compare process.
// Build with SINE_AMP_SHIFT_EN defined to exercise the attenuation port.
module tb_sine_quarter_lut;

    localparam int A    = 8;
    localparam int D    = 8;
    localparam int MIDV = 1 << (D - 1);
    localparam int HMAX = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sine_quarter_lut_if #(.A_WIDTH(A), .D_WIDTH(D)) bus ();

    sine_quarter_lut #(.A_WIDTH(A), .D_WIDTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 2;

    // Per-cycle history of what was driven; index = cycle in which it was applied.
    bit en_h  [HMAX];
    int ph_h  [HMAX];
    bit rst_h [HMAX];
    int sh_h  [HMAX];
    int cap   [1 << A];
    int exp_dout = MIDV;
    bit exp_valid;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Full-wave reference straight from the sine definition.
    function automatic int ref_dout(input int p, input int sh);
        real theta;
        real s;
        int  m;
        theta = 2.0 * 3.14159265358979323846 * (real'(p) + 0.5) / real'(1 << A);
        s     = $sin(theta);
        m     = $rtoi(real'(MIDV - 1) * (s < 0.0 ? -s : s) + 0.5) >>> sh;
        return (s < 0.0) ? (MIDV - m) : (MIDV + m);
    endfunction

    task automatic step(input bit e, input int p, input bit r, input int sh);
        @(posedge clk);
        #1;
        cyc++;
        bus.en    = e;
        bus.phase = A'(p);
        rst       = r;
`ifdef SINE_AMP_SHIFT_EN
        bus.amp_shift = 2'(sh);
`endif
        en_h[cyc]  = e;
        ph_h[cyc]  = p;
        rst_h[cyc] = r;
        sh_h[cyc]  = sh;
    endtask

    // Outputs seen in cycle t come from the edge opening t: S3 of a sample driven in t-3.
    always @(negedge clk) begin
        if (cyc >= 5) begin
            if (rst_h[cyc-1]) begin
                exp_valid = 1'b0;
                exp_dout  = MIDV;
            end else begin
                exp_valid = en_h[cyc-3] && !rst_h[cyc-3] && !rst_h[cyc-2];
                if (exp_valid) begin
                    exp_dout = ref_dout(ph_h[cyc-3], sh_h[cyc-1]);
                end
            end
            check("dout_valid", int'(bus.dout_valid), int'(exp_valid));
            check("dout", int'(bus.dout), exp_dout);
            if (exp_valid && bus.dout_valid) begin
                cap[ph_h[cyc-3]] = int'(bus.dout);
                $display("sample cyc=%0d phase=%0d shift=%0d dout=%0d", cyc, ph_h[cyc-3],
                         sh_h[cyc-1], bus.dout);
            end
        end
    end

    initial begin
        for (int i = 0; i < HMAX; i++) begin
            en_h[i]  = 1'b0;
            rst_h[i] = 1'b1;
            ph_h[i]  = 0;
            sh_h[i]  = 0;
        end
        bus.en    = 1'b0;
        bus.phase = '0;
`ifdef SINE_AMP_SHIFT_EN
        bus.amp_shift = 2'd0;
`endif

        // Hand-computed anchors for the model itself.
        check("model_p0",   ref_dout(0, 0),   130);
        check("model_p63",  ref_dout(63, 0),  255);
        check("model_p64",  ref_dout(64, 0),  255);
        check("model_p128", ref_dout(128, 0), 126);
        check("model_p192", ref_dout(192, 0), 1);

        // Reset for two cycles, then idle.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

        // Single pulse at the positive peak.
        cap[64] = -1;
        step(1, 64, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        check("pulse_p64", cap[64], 255);

        // Full sweep back to back, including the wrap.
        for (int i = 0; i < (1 << A); i++) cap[i] = -1;
        for (int p = 0; p < (1 << A); p++) step(1, p, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("sweep_p0",   cap[0],   130);
        check("sweep_p63",  cap[63],  255);
        check("sweep_p128", cap[128], 126);
        check("sweep_p192", cap[192], 1);
        for (int p = 0; p < (1 << (A - 1)); p++) begin
            check("symmetry", cap[p] + cap[p + (1 << (A - 1))], 1 << D);
        end

        // Gapped enable pattern.
        step(1, $urandom_range(255), 0, 0);
        step(0, $urandom_range(255), 0, 0);
        step(1, $urandom_range(255), 0, 0);
        step(1, $urandom_range(255), 0, 0);
        step(0, $urandom_range(255), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Reset while samples are in flight, then resume the stream.
        for (int i = 0; i < 4; i++) step(1, $urandom_range(255), 0, 0);
        step(1, $urandom_range(255), 1, 0);
        for (int i = 0; i < 6; i++) step(1, $urandom_range(255), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

`ifdef SINE_AMP_SHIFT_EN
        cap[64]  = -1;
        cap[192] = -1;
        step(1, 64, 0, 2);
        step(1, 192, 0, 2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 2);
        check("shift2_p64",  cap[64],  159);
        check("shift2_p192", cap[192], 97);
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
`ifdef SINE_AMP_SHIFT_EN
            step(($urandom_range(3) != 0), $urandom_range(255),
                 ($urandom_range(49) == 0), $urandom_range(3));
`else
            step(($urandom_range(3) != 0), $urandom_range(255),
                 ($urandom_range(49) == 0), 0);
`endif
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
